// File: rtl/csa8_operand_sequencer.sv
// Streaming operand collector and sequencer for an 8-operand carry-save adder.
// Buffers up to eight operands, reduces them through a 3:2 compressor tree and holds the sum for handshake.
module csa8_operand_sequencer #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+2:0]   out_sum,
    output logic [3:0]     out_count,
    output logic           busy
);

    localparam int W = N + 3;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] c;
    } csa_t;

    logic [1:0]   state;
    logic [2:0]   idx;
    logic [3:0]   count;
    logic [N-1:0] slot [8];

    logic [W-1:0] op [8];
    csa_t         l1_a, l1_b, l2_a, l2_b, l3, l4;
    logic [W-1:0] csa_sum;

    // Sum bits plus shifted carry; truncation to W is exact because the true total fits in W bits.
    function automatic csa_t csa3(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

    // NOTE: every signal in this block is assigned on every pass, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            op[i] = {3'b000, slot[i]};
        end
        l1_a    = csa3(op[0], op[1], op[2]);
        l1_b    = csa3(op[3], op[4], op[5]);
        l2_a    = csa3(l1_a.s, l1_a.c, l1_b.s);
        l2_b    = csa3(l1_b.c, op[6], op[7]);
        l3      = csa3(l2_a.s, l2_a.c, l2_b.s);
        l4      = csa3(l3.s, l3.c, l2_b.c);
        csa_sum = l4.s + l4.c;
    end

    assign in_ready  = (state == ST_COLLECT);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_COLLECT) || (idx != 3'd0);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_COLLECT;
            idx       <= 3'd0;
            count     <= 4'd0;
            out_sum   <= '0;
            out_count <= 4'd0;
            // NOTE: the operand buffer is reset on purpose; unused slots must read as zero in the sum.
            for (int i = 0; i < 8; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        slot[idx] <= in_data;
                        idx       <= idx + 3'd1;
                        if (in_last || idx == 3'd7) begin
                            state <= ST_COMPUTE;
                            count <= {1'b0, idx} + 4'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    out_sum   <= csa_sum;
                    out_count <= count;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_COLLECT;
                        idx   <= 3'd0;
                        for (int i = 0; i < 8; i++) begin
                            slot[i] <= '0;
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_csa8_operand_sequencer.sv
// Directed self-checking bench for csa8_operand_sequencer with N=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_csa8_operand_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N+2:0] out_sum;
    logic [3:0]   out_count;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    csa8_operand_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Presents one beat; it is accepted at the next rising edge once in_ready is high.
    task automatic send(input logic [N-1:0] d, input logic last);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, then completes the handshake.
    task automatic expect_result(input string tag, input int sum, input int cnt);
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'(sum));
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    logic       gap_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] gap_d [8] = '{4'd2, 4'd9, 4'd4, 4'd15, 4'd7, 4'd6, 4'd3, 4'd8};
    logic       gap_l [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Full group of eight without in_last, exact latency.
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), 1'b0);
            if (i == 2) check("full_busy", 32'(busy), 32'd1);
        end
        idle();
        check("full_ready_drop", 32'(in_ready), 32'd0);
        check("full_compute_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("full_latency", 32'(out_valid), 32'd1);
        expect_result("full", 36, 8);

        // Maximum operands, in_last on the 8th beat.
        for (int i = 1; i <= 8; i++) send(4'd15, i == 8);
        idle();
        expect_result("max", 120, 8);

        // Short group, then a single beat proving the slots were cleared.
        send(4'd9, 1'b0);
        send(4'd6, 1'b0);
        send(4'd3, 1'b1);
        idle();
        expect_result("short", 18, 3);
        send(4'd5, 1'b1);
        idle();
        expect_result("single", 5, 1);

        // Backpressure: result held while the producer keeps in_valid high.
        send(4'd3, 1'b0);
        send(4'd4, 1'b1);
        idle();
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd15;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'd7);
            check("bp_count", 32'(out_count), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        check("bp_not_busy", 32'(busy), 32'd0);

        // Input gaps with garbage data and in_last on non-valid cycles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = gap_v[i];
            in_data  = gap_d[i];
            in_last  = gap_l[i];
        end
        idle();
        expect_result("gaps", 20, 4);

        // Reset after five accepted beats discards the group.
        for (int i = 1; i <= 5; i++) send(4'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("midrst_no_beat", 32'(out_valid), 32'd0);
        send(4'd1, 1'b0);
        send(4'd1, 1'b1);
        idle();
        expect_result("post_rst", 2, 2);

        // Reset while a result is pending drops it.
        send(4'd7, 1'b1);
        idle();
        @(negedge clk);
        check("holdrst_pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("holdrst_valid", 32'(out_valid), 32'd0);
        check("holdrst_sum", 32'(out_sum), 32'd0);
        send(4'd2, 1'b1);
        idle();
        expect_result("after_holdrst", 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
